// File: rtl/uart_frame_chk.sv
// UART RX frame checker: assembles LSB-first data, checks optional parity and 1/2 stop bits, counts errors.
// Latency: completion outputs (data_valid/data_out/flags/counters) appear the cycle after the final bit_vld.
// Backpressure: none; bit strobes are consumed as they arrive, frame_start aborts/restarts at any time.
//
// Ports:
//   clk, rst (async active-low)          : clock and reset
//   frame_start, bit_vld, sampled_bit    : strobes and line value from the RX sampler
//   par_en, par_typ, stp2                : frame format, latched on frame_start
//   err_clr                              : synchronous clear of both error counters
//   data_out, data_valid, par_err, stp_err, busy, par_err_cnt, stp_err_cnt : results
module uart_frame_chk #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  bit_vld,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stp2,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

    localparam int                  IDX_W    = 4;
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {IDLE, DATA, PAR, STOP1, STOP2} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  acc_q, acc_d;
    logic                  par_en_l_q, par_en_l_d;
    logic                  par_typ_l_q, par_typ_l_d;
    logic                  stp2_l_q, stp2_l_d;
    logic                  pend_par_q, pend_par_d;
    logic                  pend_stp_q, pend_stp_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic [CNT_WIDTH-1:0]  par_cnt_q, par_cnt_d;
    logic [CNT_WIDTH-1:0]  stp_cnt_q, stp_cnt_d;

    logic final_bit;
    logic fin_stp;

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        acc_d        = acc_q;
        par_en_l_d   = par_en_l_q;
        par_typ_l_d  = par_typ_l_q;
        stp2_l_d     = stp2_l_q;
        pend_par_d   = pend_par_q;
        pend_stp_d   = pend_stp_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;
        par_cnt_d    = par_cnt_q;
        stp_cnt_d    = stp_cnt_q;

        // The last stop bit completes the frame even if frame_start arrives
        // in the same cycle; the new frame is then set up below.
        final_bit = bit_vld && ((state_q == STOP1 && !stp2_l_q) || state_q == STOP2);
        fin_stp   = pend_stp_q | ~sampled_bit;

        if (final_bit) begin
            data_valid_d = 1'b1;
            data_out_d   = shreg_q;
            par_err_d    = pend_par_q;   // only ever set in PAR, so 0 without parity
            stp_err_d    = fin_stp;
            state_d      = IDLE;
            if (pend_par_q && par_cnt_q != CNT_MAX) par_cnt_d = par_cnt_q + CNT_ONE;
            if (fin_stp && stp_cnt_q != CNT_MAX)    stp_cnt_d = stp_cnt_q + CNT_ONE;
        end

        if (frame_start) begin
            // Start or abort-and-restart; any coincident non-final bit_vld is dropped.
            state_d     = DATA;
            bit_idx_d   = '0;
            shreg_d     = '0;
            acc_d       = 1'b0;
            pend_par_d  = 1'b0;
            pend_stp_d  = 1'b0;
            par_en_l_d  = par_en;
            par_typ_l_d = par_typ;
            stp2_l_d    = stp2;
        end else if (bit_vld) begin
            unique case (state_q)
                DATA: begin
                    shreg_d   = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
                    acc_d     = acc_q ^ sampled_bit;
                    bit_idx_d = bit_idx_q + IDX_ONE;
                    if (bit_idx_q == IDX_LAST) state_d = par_en_l_q ? PAR : STOP1;
                end
                PAR: begin
                    pend_par_d = acc_q ^ sampled_bit ^ par_typ_l_q;
                    state_d    = STOP1;
                end
                STOP1: begin
                    pend_stp_d = fin_stp;
                    if (stp2_l_q) state_d = STOP2;
                end
                default: ;  // IDLE ignores strobes; STOP2 handled by completion
            endcase
        end

        // Clear wins over a coincident increment.
        if (err_clr) begin
            par_cnt_d = '0;
            stp_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            acc_q        <= 1'b0;
            par_en_l_q   <= 1'b0;
            par_typ_l_q  <= 1'b0;
            stp2_l_q     <= 1'b0;
            pend_par_q   <= 1'b0;
            pend_stp_q   <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            par_cnt_q    <= '0;
            stp_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            acc_q        <= acc_d;
            par_en_l_q   <= par_en_l_d;
            par_typ_l_q  <= par_typ_l_d;
            stp2_l_q     <= stp2_l_d;
            pend_par_q   <= pend_par_d;
            pend_stp_q   <= pend_stp_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            par_cnt_q    <= par_cnt_d;
            stp_cnt_q    <= stp_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;
    assign busy        = (state_q != IDLE);
    assign par_err_cnt = par_cnt_q;
    assign stp_err_cnt = stp_cnt_q;

endmodule

// File: doc/uart_frame_chk.md
Name: uart_frame_chk

Overview:
- Parametrised UART RX frame checker.
- Generalises the single-bit stop-bit check into a sequential checker for one whole frame: data bits, optional parity, and 1 or 2 stop bits.
- Assembles the data word, checks parity and every stop bit, and keeps saturating error counters.
- Sits between the RX sampler (bit strobes) and the RX FSM/output register.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; legal range 5..9.
- CNT_WIDTH, 8, width of each saturating error counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- frame_start  input  1  one-cycle pulse: a valid start bit has been detected.
- bit_vld  input  1  one-cycle pulse: sampled_bit holds the next frame bit.
- sampled_bit  input  1  majority-sampled line value.
- par_en  input  1  1 = frame carries a parity bit.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- stp2  input  1  1 = two stop bits, 0 = one stop bit.
- err_clr  input  1  synchronous clear of both error counters.
- data_out  output  DATA_WIDTH  last completed data word.
- data_valid  output  1  one-cycle frame-complete pulse.
- par_err  output  1  parity error of the last completed frame.
- stp_err  output  1  stop error of the last completed frame.
- busy  output  1  high while a frame is in progress.
- par_err_cnt  output  CNT_WIDTH  number of frames with a parity error.
- stp_err_cnt  output  CNT_WIDTH  number of frames with a stop error.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs, counters, shift register and parity accumulator are 0.
- FSM states: IDLE, DATA, PAR, STOP1, STOP2.
- busy = (state != IDLE).
- Config latch: par_en, par_typ and stp2 are latched on frame_start. Changes to them mid-frame have no effect on that frame.
- IDLE:
  - bit_vld is ignored.
  - frame_start -> DATA; bit_idx=0, parity accumulator=0.
- DATA:
  - Each bit_vld shifts sampled_bit in, LSB first, XORs it into the accumulator, and increments bit_idx.
  - On the bit_vld with bit_idx==DATA_WIDTH-1: go to PAR if latched par_en, else STOP1.
- PAR:
  - On bit_vld, compute the pending parity error = acc ^ sampled_bit ^ par_typ_l.
  - Then go to STOP1.
- STOP1:
  - On bit_vld, the pending stop error |= ~sampled_bit.
  - Then go to STOP2 if latched stp2, else complete the frame.
- STOP2:
  - On bit_vld, the pending stop error |= ~sampled_bit.
  - Then complete the frame.
- Completion, registered on the edge that samples the final bit_vld (outputs visible in the next cycle):
  - data_valid=1 for exactly one cycle.
  - data_out, par_err and stp_err are updated; all three hold until the next completion.
  - State returns to IDLE.
  - data_valid pulses even when errors are present; the consumer qualifies the data with the error flags.
  - par_err is 0 whenever the latched par_en is 0.
- Counters:
  - On completion, par_err_cnt increments if the frame has a parity error; stp_err_cnt increments if it has a stop error.
  - Maximum one increment per counter per frame: a frame with both stop bits bad counts once.
  - Counters saturate at 2^CNT_WIDTH-1; no wrap.
  - err_clr zeroes both counters. If err_clr coincides with an increment, clear wins and the result is 0.
  - err_clr does not affect par_err or stp_err.
- Abort: frame_start in any non-IDLE state discards the frame in progress.
  - No data_valid, no counter update, for the discarded frame.
  - The checker restarts in DATA with freshly latched config.
- frame_start in the same cycle as the final bit_vld of a frame:
  - The old frame completes normally (data_valid follows).
  - The new frame starts in DATA.
- bit_vld and frame_start in the same cycle with frame_start not aborting a final bit: frame_start has priority and that bit_vld is discarded.
- Reset asserted mid-frame: the frame is dropped and all state returns to reset values immediately.

Test Plan:
- 8N1, data 0xA5 (LSB first), stop=1 -> data_out=0xA5, data_valid is a 1-cycle pulse one cycle after the stop bit_vld, par_err=0, stp_err=0, counters 0.
- 8E1, data 0x07, parity bit=1 -> par_err=0. Repeat with parity bit=0 -> par_err=1, par_err_cnt=1. 8O1 with 0x07 and parity bit=0 -> par_err=0.
- 8N2, data 0x3C, stop bits 1 then 0 -> stp_err=1, stp_err_cnt=1. Stop bits 0,0 -> stp_err_cnt=2 (one increment for that frame).
- Abort: frame_start, 4 data bits, frame_start, then full 8N1 frame 0x3C -> exactly one data_valid, data_out=0x3C, busy stays high throughout.
- Saturation and clear: CNT_WIDTH=2, five bad-stop frames -> stp_err_cnt=3. err_clr coincident with a 6th bad frame's completion -> count reads 0.
- Reset mid-frame: rst low after 3 data bits -> busy=0 and all outputs 0. The next full frame 0x5A decodes correctly.
